instr_result_checker: RTL and testbench
=======================================

# instr_result_checker

Readback-and-check stage downstream of the instruction register file. On a start command it sweeps a contiguous window of register entries through `read_pointer`, samples the returned instruction word, recomputes the expected result from opcode and operands, and counts pass, fail and skip outcomes. It gives the lab bench a self-checking hardware scoreboard and reports every mismatch with its address.

## Interface
- `ADDR_W`, default 5, width of `read_pointer`; the file depth is 2^ADDR_W = 32.
- `OP_W`, default 32, width of a signed operand (`operand_t`).
- `RES_W`, default 64, width of a signed result (`result_t`).
- `CNT_W`, default 6, width of the outcome counters; it must hold 2^ADDR_W.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`=1.
- `first_addr`  in  ADDR_W  first entry to check; latched when `start` is accepted.
- `num_entries`  in  ADDR_W+1  number of entries to check; latched with `start`; 0 means 32.
- `read_pointer`  out  ADDR_W  registered address driven to the register file.
- `instruction_word`  in  `instruction_t`  combinational read data, with fields opc[3:0], op_a, op_b, op_c and result.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass_count`, `fail_count`, `skip_count`  out  CNT_W each  outcome counters for the current or last sweep.
- `err_valid`  out  1  one-cycle pulse per mismatching entry.
- `err_addr`  out  ADDR_W  address of the mismatch; held until the next mismatch.
- `err_expected`  out  RES_W  recomputed result for the mismatch; held until the next mismatch.

## Operation
- States are IDLE, SWEEP and DRAIN.
- IDLE → SWEEP when `start`=1. On that edge the block:
  - latches `first_addr` and `num_entries`;
  - clears all three counters;
  - loads `read_pointer` with `first_addr`.
- SWEEP: `read_pointer` increments by 1 every cycle, modulo 32 (31 wraps to 0). After the last address has been issued the FSM moves to DRAIN.
- DRAIN: the FSM waits for the two pipeline stages to empty. It then asserts `done` for one cycle and returns to IDLE.
- Pipeline stage 1 registers `instruction_word` and its address.
- Pipeline stage 2 compares the registered result with the expected result and updates the counters.
- Expected result is computed as signed arithmetic on operands sign-extended to RES_W:
  - ZERO(0) → 0
  - PASSA(1) → a
  - PASSB(2) → b
  - ADD(3) → a+b+c
  - SUB(4) → a−b
  - MULT(5) → a×b, full 64-bit product
  - DIV(6) → a/b, truncated toward zero
  - MOD(7) → a%b, sign of a
- Skip cases: DIV or MOD with b=0, and any opc 8–15, increment `skip_count` only. No compare is made and `err_valid` stays low.
- Compare outcome: a match increments `pass_count`. A mismatch increments `fail_count`, pulses `err_valid` and updates `err_addr` and `err_expected`.
- Invariant: at `done`, pass+fail+skip equals the number of entries swept.
- `read_pointer` holds its last value in IDLE and DRAIN.

## Timing
- Reset value of every output is 0, and the FSM resets to IDLE.
- Reset asserted mid-sweep aborts the sweep immediately: counters clear and `done` does not pulse.
- Cycle numbering is relative to the edge t at which `start` is accepted:
  - `read_pointer`=first_addr+k (mod 32) is visible after edge t+k, for k=0..N−1.
  - Entry k is sampled at edge t+k+1.
  - Counters and `err_*` for entry k update at edge t+k+2.
- `busy` rises at edge t and falls at edge t+N+2. `done` is high for exactly the cycle following edge t+N+2.
- Minimum sweep length (start to done) is N+2 cycles. Throughput is one entry per cycle.
- `start` in the same cycle that `done` is high is accepted (the FSM is in IDLE by then).
- The register file must not be written during a sweep; a word read under a concurrent write is checked as read.

## Test plan
- Load entry 0 with ADD a=5 b=−3 c=10 result=12; `start` with first_addr=0, num_entries=1 → after 3 cycles pass=1, fail=0, skip=0, one `done` pulse.
- Load entry 3 with MULT a=−70000 b=70000 and a corrupted result of 0; sweep addr 3, N=1 → fail=1, `err_addr`=3, `err_expected`=−4 900 000 000.
- Load entry 4 with DIV b=0 and entry 5 with opc=12; sweep 4..5 → skip=2, pass=0, `err_valid` never high.
- Sweep with first_addr=30, num_entries=4 → `read_pointer` sequence 30, 31, 0, 1 and counters total 4.
- Sweep with num_entries=0 after a reset (all entries ZERO, result 0) → pass=32, `busy` high for 34 cycles.
- Assert reset_n low 5 cycles into a 32-entry sweep → all outputs 0 immediately and no `done`; a subsequent `start` completes normally.

Source files
------------

// File: rtl/instr_result_checker.sv
// Readback checker: sweeps a window of the instruction register file, recomputes each
// entry's result from opcode and operands, and counts pass/fail/skip outcomes.
package instr_result_checker_pkg;
  localparam int INSTR_OP_W  = 32;
  localparam int INSTR_RES_W = 64;

  typedef logic signed [INSTR_OP_W-1:0]  operand_t;
  typedef logic signed [INSTR_RES_W-1:0] result_t;

  typedef struct packed {
    logic [3:0] opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_t   op_c;
    result_t    result;
  } instruction_t;
endpackage

module instr_result_checker
  import instr_result_checker_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W   = instr_result_checker_pkg::INSTR_OP_W,
  parameter int RES_W  = instr_result_checker_pkg::INSTR_RES_W,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       first_addr,
  input  logic [ADDR_W:0]         num_entries,
  output logic [ADDR_W-1:0]       read_pointer,
  input  instruction_t            instruction_word,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        pass_count,
  output logic [CNT_W-1:0]        fail_count,
  output logic [CNT_W-1:0]        skip_count,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       err_addr,
  output logic signed [RES_W-1:0] err_expected
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t              state, next_state;
  logic                accept, advance;
  logic [ADDR_W:0]     remaining;
  logic                s1_vld;
  logic [ADDR_W-1:0]   s1_addr;
  instruction_t        s1_word;

  logic signed [RES_W-1:0] a, b, c, expected;
  logic signed [OP_W-1:0]  op_b;
  logic                    skip;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SWEEP;
          accept     = 1'b1;
        end
      end
      SWEEP: begin
        if (remaining == (ADDR_W+1)'(1)) next_state = DRAIN;
        else                             advance    = 1'b1;
      end
      // Stage 2 retires in the same edge that empties stage 1.
      DRAIN: begin
        if (!s1_vld) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    a        = RES_W'(signed'(s1_word.op_a));
    b        = RES_W'(signed'(s1_word.op_b));
    c        = RES_W'(signed'(s1_word.op_c));
    op_b     = s1_word.op_b;
    expected = '0;
    skip     = 1'b0;
    case (s1_word.opc)
      4'd0: expected = '0;
      4'd1: expected = a;
      4'd2: expected = b;
      4'd3: expected = a + b + c;
      4'd4: expected = a - b;
      4'd5: expected = a * b;
      4'd6: if (op_b == '0) skip = 1'b1; else expected = a / b;
      4'd7: if (op_b == '0) skip = 1'b1; else expected = a % b;
      default: skip = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      remaining    <= '0;
      done         <= 1'b0;
      s1_vld       <= 1'b0;
      s1_addr      <= '0;
      s1_word      <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      skip_count   <= '0;
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_expected <= '0;
    end else begin
      done      <= (state == DRAIN) && !s1_vld;
      err_valid <= 1'b0;

      if (accept) begin
        read_pointer <= first_addr;
        remaining    <= (num_entries == '0) ? {1'b1, {ADDR_W{1'b0}}} : num_entries;
      end else if (advance) begin
        read_pointer <= read_pointer + ADDR_W'(1);
        remaining    <= remaining - (ADDR_W+1)'(1);
      end

      s1_vld  <= (state == SWEEP);
      s1_addr <= read_pointer;
      s1_word <= instruction_word;

      if (accept) begin
        pass_count <= '0;
        fail_count <= '0;
        skip_count <= '0;
      end else if (s1_vld) begin
        if (skip) begin
          skip_count <= skip_count + CNT_W'(1);
        end else if (s1_word.result == expected) begin
          pass_count <= pass_count + CNT_W'(1);
        end else begin
          fail_count   <= fail_count + CNT_W'(1);
          err_valid    <= 1'b1;
          err_addr     <= s1_addr;
          err_expected <= expected;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_result_checker.sv
// Scoreboard bench: sweeps push expected outcomes; a negedge monitor checks done/err pulses.
module tb_instr_result_checker;
  import instr_result_checker_pkg::*;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   first_addr = '0;
  logic [ADDR_W:0]     num_entries = '0;
  logic [ADDR_W-1:0]   read_pointer;
  instruction_t        instruction_word;
  logic                busy, done, err_valid;
  logic [CNT_W-1:0]    pass_count, fail_count, skip_count;
  logic [ADDR_W-1:0]   err_addr;
  logic signed [63:0]  err_expected;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  instr_result_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_addr(first_addr),
    .num_entries(num_entries), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .skip_count(skip_count),
    .err_valid(err_valid), .err_addr(err_addr), .err_expected(err_expected)
  );

  always #5 clk = ~clk;

  typedef struct { int first; int n; int pass; int fail; int skip; } sweep_t;
  typedef struct { int addr; longint expv; } err_t;

  sweep_t sweep_q[$];
  err_t   err_q[$];
  int     checks = 0;
  int     passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor
  int     busy_cyc = 0;
  int     ptr_seen[$];
  sweep_t s_cur;
  err_t   e_cur;
  int     bad;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cyc = 0;
      ptr_seen.delete();
    end else begin
      if (busy) begin
        busy_cyc++;
        ptr_seen.push_back(int'(read_pointer));
      end
      if (err_valid) begin
        check("err_expected_by_bench", longint'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          e_cur = err_q.pop_front();
          check("err_addr", longint'(err_addr), longint'(e_cur.addr));
          check("err_expected", err_expected, e_cur.expv);
        end
      end
      if (done) begin
        check("done_expected_by_bench", longint'(sweep_q.size() > 0), 1);
        if (sweep_q.size() > 0) begin
          s_cur = sweep_q.pop_front();
          check("pass_count", longint'(pass_count), longint'(s_cur.pass));
          check("fail_count", longint'(fail_count), longint'(s_cur.fail));
          check("skip_count", longint'(skip_count), longint'(s_cur.skip));
          check("busy_cycles", longint'(busy_cyc), longint'(s_cur.n + 2));
          bad = 0;
          for (int i = 0; i < s_cur.n; i++)
            if (i >= ptr_seen.size() || ptr_seen[i] != (s_cur.first + i) % 32) bad++;
          check("ptr_seq_mismatches", longint'(bad), 0);
        end
        busy_cyc = 0;
        ptr_seen.delete();
      end
    end
  end

  task automatic set_entry(input int addr, input int opc, input int a, input int b,
                           input int c, input longint res);
    mem[addr].opc    = 4'(opc);
    mem[addr].op_a   = a;
    mem[addr].op_b   = b;
    mem[addr].op_c   = c;
    mem[addr].result = res;
  endtask

  task automatic expect_err(input int addr, input longint expv);
    err_t e;
    e.addr = addr;
    e.expv = expv;
    err_q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_within_budget", longint'(k < 200), 1);
  endtask

  task automatic run_sweep(input int fa, input int n, input int p, input int f, input int s);
    sweep_t x;
    x.first = fa; x.n = (n == 0) ? 32 : n; x.pass = p; x.fail = f; x.skip = s;
    sweep_q.push_back(x);
    @(negedge clk);
    start       = 1'b1;
    first_addr  = ADDR_W'(fa);
    num_entries = (ADDR_W+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_pointer"}, longint'(read_pointer), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_pass"}, longint'(pass_count), 0);
    check({tag, "_fail"}, longint'(fail_count), 0);
    check({tag, "_skip"}, longint'(skip_count), 0);
    check({tag, "_err_valid"}, longint'(err_valid), 0);
    check({tag, "_err_addr"}, longint'(err_addr), 0);
    check({tag, "_err_expected"}, err_expected, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ADD 5 + (-3) + 10 = 12
    set_entry(0, 3, 5, -3, 10, 12);
    run_sweep(0, 1, 1, 0, 0);

    // MULT with corrupted result
    set_entry(3, 5, -70000, 70000, 0, 0);
    expect_err(3, -64'sd4900000000);
    run_sweep(3, 1, 0, 1, 0);

    // DIV by zero and an undefined opcode are both skipped
    set_entry(4, 6, 17, 0, 0, 0);
    set_entry(5, 12, 1, 2, 3, 4);
    run_sweep(4, 2, 0, 0, 2);

    // Wrap 30,31,0,1: SUB, DIV trunc toward zero, ADD, MOD with a bad result
    set_entry(30, 4, 100, -25, 0, 125);
    set_entry(31, 6, -7, 2, 0, -3);
    set_entry(1, 7, -7, 2, 0, 1);
    expect_err(1, -1);
    run_sweep(30, 4, 3, 1, 0);

    // Full 32-entry sweep of ZERO entries after a reset
    pulse_reset();
    for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0, 0, 0);
    run_sweep(0, 0, 32, 0, 0);

    // Abort a 32-entry sweep with reset five cycles in
    @(negedge clk);
    start       = 1'b1;
    first_addr  = ADDR_W'(0);
    num_entries = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_busy_stays_low", longint'(busy), 0);

    // Subsequent sweep: PASSA, PASSB, ZERO with a wrong stored result
    set_entry(2, 1, -9, 5, 0, -9);
    set_entry(3, 2, 11, 42, 0, 42);
    set_entry(4, 0, 1, 1, 1, 7);
    expect_err(4, 0);
    run_sweep(2, 3, 2, 1, 0);

    repeat (5) @(negedge clk);
    check("sweeps_pending", longint'(sweep_q.size()), 0);
    check("errs_pending", longint'(err_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
